// File: rtl/led_sequence_ctrl.sv
// Button-driven LED sequencer: synchronizes and debounces four active-low buttons,
// turns each press into one command and steps an 8-bit counter/rotate pattern.
module led_sequence_ctrl #(
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int TICK_CYCLES     = 20_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] button,
    output logic [7:0] led,
    output logic       run,
    output logic       dir_down,
    output logic       shift_mode
);

    localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    logic [3:0]    sync1_q;
    logic [3:0]    sync2_q;
    logic [3:0]    deb_q;
    logic [3:0]    press_q;
    logic [DW-1:0] cnt_q [4];

    state_t        state_q;
    logic [7:0]    value_q;
    logic [7:0]    value_d;
    logic [TW-1:0] presc_q;
    logic          run_q;
    logic          dir_q;
    logic          mode_q;

    logic          cmd_start;
    logic          cmd_dir;
    logic          cmd_mode;
    logic          cmd_clear;

    // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples;
    // the press pulse is raised on the same edge the debounced level falls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
            deb_q   <= '1;
            press_q <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= button;
            sync2_q <= sync1_q;
            press_q <= '0;
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] != deb_q[i]) begin
                    if (cnt_q[i] == DEB_LAST) begin
                        cnt_q[i]   <= '0;
                        deb_q[i]   <= sync2_q[i];
                        press_q[i] <= ~sync2_q[i];
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    // Lowest-index press wins; the rest are dropped.
    always_comb begin
        cmd_start = 1'b0;
        cmd_dir   = 1'b0;
        cmd_mode  = 1'b0;
        cmd_clear = 1'b0;
        if (press_q[0])      cmd_start = 1'b1;
        else if (press_q[1]) cmd_dir   = 1'b1;
        else if (press_q[2]) cmd_mode  = 1'b1;
        else if (press_q[3]) cmd_clear = 1'b1;
    end

    always_comb begin
        value_d = value_q;
        if (!mode_q) begin
            value_d = dir_q ? value_q - 8'd1 : value_q + 8'd1;
        end else if (value_q == 8'h00) begin
            value_d = 8'h01;
        end else begin
            value_d = dir_q ? {value_q[0], value_q[7:1]} : {value_q[6:0], value_q[7]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            value_q <= '0;
            presc_q <= '0;
            run_q   <= 1'b0;
            dir_q   <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            if (cmd_dir)  dir_q  <= ~dir_q;
            if (cmd_mode) mode_q <= ~mode_q;
            case (state_q)
                IDLE: begin
                    value_q <= '0;
                    presc_q <= '0;
                    if (cmd_start) begin
                        state_q <= RUN;
                        run_q   <= 1'b1;
                    end
                end
                RUN: begin
                    if (cmd_start) begin
                        state_q <= PAUSE;
                        run_q   <= 1'b0;
                    end else if (cmd_clear) begin
                        state_q <= IDLE;
                        run_q   <= 1'b0;
                        value_q <= '0;
                        presc_q <= '0;
                    end else if (presc_q == TICK_LAST) begin
                        presc_q <= '0;
                        value_q <= value_d;
                    end else begin
                        presc_q <= presc_q + 1'b1;
                    end
                end
                PAUSE: begin
                    if (cmd_start) begin
                        state_q <= RUN;
                        run_q   <= 1'b1;
                    end else if (cmd_clear) begin
                        state_q <= IDLE;
                        value_q <= '0;
                        presc_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    run_q   <= 1'b0;
                    value_q <= '0;
                    presc_q <= '0;
                end
            endcase
        end
    end

    assign led        = ~value_q;
    assign run        = run_q;
    assign dir_down   = dir_q;
    assign shift_mode = mode_q;

endmodule

// File: tb/tb_led_sequence_ctrl.sv
// Directed bench for led_sequence_ctrl with DEBOUNCE_CYCLES=4, TICK_CYCLES=8.
// Inputs change and outputs are sampled 1 ns after a rising edge; edge numbers below count from the press.
module tb_led_sequence_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] button;
    logic [7:0] led;
    logic       run;
    logic       dir_down;
    logic       shift_mode;

    int checkCount = 0;
    int errorCount = 0;

    led_sequence_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .TICK_CYCLES    (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .button    (button),
        .led       (led),
        .run       (run),
        .dir_down  (dir_down),
        .shift_mode(shift_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] mask, input int hold, input int gap);
        button = ~mask;
        waitEdges(hold);
        button = 4'hF;
        waitEdges(gap);
    endtask

    task automatic doReset();
        reset = 1'b1;
        waitEdges(2);
        reset = 1'b0;
        waitEdges(2);
    endtask

    initial begin
        reset  = 1'b1;
        button = 4'hF;
        #1;
        checkOutput("por_led", 32'(led), 32'hFF);
        checkOutput("por_run", 32'(run), 32'h0);
        checkOutput("por_dir", 32'(dir_down), 32'h0);
        checkOutput("por_mode", 32'(shift_mode), 32'h0);
        waitEdges(3);
        reset = 1'b0;
        waitEdges(2);

        // Start/count: run rises at edge 7, first step at edge 15, then every 8 edges.
        button = 4'b1110;
        waitEdges(6);
        checkOutput("start_run_e6", 32'(run), 32'h0);
        waitEdges(1);
        checkOutput("start_run_e7", 32'(run), 32'h1);
        checkOutput("start_led_e7", 32'(led), 32'hFF);
        waitEdges(3);
        button = 4'hF;
        waitEdges(4);
        checkOutput("count_led_e14", 32'(led), 32'hFF);
        waitEdges(1);
        checkOutput("count_led_e15", 32'(led), 32'hFE);
        waitEdges(8);
        checkOutput("count_led_e23", 32'(led), 32'hFD);
        waitEdges(8);
        checkOutput("count_led_e31", 32'(led), 32'hFC);
        doReset();

        // Glitch rejection, then a 12-cycle hold gives exactly one start.
        applyStimulus(4'b0001, 2, 20);
        checkOutput("glitch_run", 32'(run), 32'h0);
        checkOutput("glitch_led", 32'(led), 32'hFF);
        applyStimulus(4'b0001, 12, 10);
        checkOutput("hold12_run", 32'(run), 32'h1);
        doReset();

        // Rotate mode up, then direction flip while running.
        applyStimulus(4'b0100, 10, 10);
        checkOutput("rot_mode", 32'(shift_mode), 32'h1);
        checkOutput("rot_idle_led", 32'(led), 32'hFF);
        button = 4'b1110;
        waitEdges(10);
        button = 4'hF;
        waitEdges(5);
        checkOutput("rot_led_e15", 32'(led), 32'hFE);
        waitEdges(8);
        checkOutput("rot_led_e23", 32'(led), 32'hFD);
        waitEdges(8);
        checkOutput("rot_led_e31", 32'(led), 32'hFB);
        button = 4'b1101;
        waitEdges(7);
        checkOutput("rot_dir_e38", 32'(dir_down), 32'h1);
        waitEdges(1);
        checkOutput("rot_led_e39", 32'(led), 32'hFD);
        waitEdges(2);
        button = 4'hF;
        waitEdges(6);
        checkOutput("rot_led_e47", 32'(led), 32'hFE);
        waitEdges(8);
        checkOutput("rot_led_e55", 32'(led), 32'h7F);

        // Asynchronous reset: outputs clear before the next clock edge.
        waitEdges(2);
        reset = 1'b1;
        #1;
        checkOutput("areset_led", 32'(led), 32'hFF);
        checkOutput("areset_run", 32'(run), 32'h0);
        checkOutput("areset_dir", 32'(dir_down), 32'h0);
        checkOutput("areset_mode", 32'(shift_mode), 32'h0);
        waitEdges(2);
        reset = 1'b0;
        waitEdges(2);

        // Down wrap, then start+clear together on a step edge, then clear.
        applyStimulus(4'b0010, 10, 10);
        checkOutput("down_dir", 32'(dir_down), 32'h1);
        button = 4'b1110;
        waitEdges(10);
        button = 4'hF;
        waitEdges(5);
        checkOutput("down_led_e15", 32'(led), 32'h00);
        waitEdges(8);
        checkOutput("down_led_e23", 32'(led), 32'h01);
        waitEdges(1);
        button = 4'b0110;
        waitEdges(7);
        checkOutput("prio_run_e31", 32'(run), 32'h0);
        checkOutput("prio_led_e31", 32'(led), 32'h01);
        waitEdges(3);
        button = 4'hF;
        waitEdges(15);
        checkOutput("pause_led_held", 32'(led), 32'h01);
        checkOutput("pause_run", 32'(run), 32'h0);
        applyStimulus(4'b1000, 10, 10);
        checkOutput("clear_led", 32'(led), 32'hFF);
        checkOutput("clear_run", 32'(run), 32'h0);
        checkOutput("clear_dir", 32'(dir_down), 32'h1);
        checkOutput("clear_mode", 32'(shift_mode), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/led_sequence_ctrl.md
# led_sequence_ctrl

Button-driven controller for the board's LED bank. It synchronizes and debounces the four active-low push buttons and turns each press into exactly one command. A small state machine then sequences an 8-bit LED pattern, either as a counter or as a rotating bit, at a programmable step rate. It sits between the top-level `button[3:0]` pins and `led[7:0]` pins, clocked from the single-ended `clk` derived from the `sys_clkp`/`sys_clkn` pair.

## Interface
- `DEBOUNCE_CYCLES`, default 2_000_000: consecutive stable cycles required to accept a new button level (10 ms at 200 MHz); minimum 2.
- `TICK_CYCLES`, default 20_000_000: clock cycles per pattern step while running (100 ms at 200 MHz); minimum 2.
- `clk` input 1: system clock; all logic is on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `button` input 4: raw push buttons, asynchronous, active-low (1 = released).
- `led` output 8: LED drive, active-low (0 = lit); equals `~value`.
- `run` output 1: 1 while in RUN.
- `dir_down` output 1: 0 = count up / rotate left; 1 = count down / rotate right.
- `shift_mode` output 1: 0 = counter mode; 1 = rotate mode.

## Operation
- Input path, per button:
  - 2-flop synchronizer, reset to 1.
  - Debounce counter: counts consecutive cycles where the synchronized level differs from the debounced level, and clears on any agreement. On the DEBOUNCE_CYCLES-th consecutive mismatch, the debounced level takes the new value. Debounced reset value is 1.
  - A press event is a registered one-cycle pulse on a debounced 1→0 transition.
  - Releases and holds generate no events.
- Priority: if several press events occur in the same cycle, only the lowest-index button is acted on. The others are dropped, not queued.
- Commands:
  - `button[0]`: start/pause.
  - `button[1]`: toggle `dir_down`, in any state.
  - `button[2]`: toggle `shift_mode`, in any state.
  - `button[3]`: clear.
- FSM states: IDLE (reset state), RUN, PAUSE.
  - IDLE: `value`=0 and prescaler=0. `button[0]` → RUN. `button[3]` → IDLE (no-op).
  - RUN: prescaler counts 0..TICK_CYCLES-1 and wraps; a step occurs on the cycle it wraps. `button[0]` → PAUSE. `button[3]` → IDLE.
  - PAUSE: `value` and prescaler hold. `button[0]` → RUN, and the prescaler resumes from its held count. `button[3]` → IDLE.
  - Going to IDLE clears `value` and the prescaler on that edge. `dir_down` and `shift_mode` are not cleared by `button[3]`, only by `reset`.
- Step rules (all arithmetic is 8-bit, modulo 256):
  - Counter mode: `value` ± 1, with wrap 8'hFF→8'h00 and 8'h00→8'hFF.
  - Rotate mode:
    - If `value`==0, load 8'h01 regardless of direction.
    - Otherwise rotate left 1 (up) or right 1 (down). 8'h80 rotates left to 8'h01; 8'h01 rotates right to 8'h80.
  - Mode and direction in effect at the step edge apply; a toggle takes effect from the next step.
- Simultaneous command and step in one cycle: the command wins.
  - `button[0]`/`button[3]` suppress that step.
  - `button[1]`/`button[2]` toggles are registered, and that step uses the old setting.

## Timing
- Reset values: `led`=8'hFF, `run`=0, `dir_down`=0, `shift_mode`=0, `value`=0, prescaler=0, all debounced levels=1.
- Reset is asynchronous, so outputs reach their reset values without waiting for a clock. Asserting it mid-run aborts everything, including any in-flight debounce.
- Press latency: let edge 1 be the first rising edge sampling the new low level. The command's effect is visible on outputs after edge DEBOUNCE_CYCLES+3, provided the button stays low throughout.
- A low pulse shorter than DEBOUNCE_CYCLES synchronized cycles produces no event.
- Step period: exactly TICK_CYCLES cycles. The first step after IDLE→RUN occurs TICK_CYCLES edges after the RUN-entry edge.
- `led`, `run`, `dir_down` and `shift_mode` are direct register outputs or inversions of registers: no combinational path from `button`, and no extra output latency.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and TICK_CYCLES=8 with a 10 ns clock; press = hold low 10 cycles.
- Reset check: assert `reset` mid-simulation → `led`=8'hFF, `run`=0, `dir_down`=0, `shift_mode`=0 immediately, before the next clock edge.
- Start/count: press `button[0]` → `run`=1 after edge 7. `led` then steps 8'hFE, 8'hFD, 8'hFC, one step every 8 cycles.
- Glitch rejection: `button[0]` low for 2 cycles, then high → no change on any output. A 12-cycle hold produces exactly one toggle.
- Rotate mode:
  - Press `button[2]` in IDLE, then `button[0]` → `value` goes 8'h01, 8'h02, 8'h04 (`led` 8'hFE, 8'hFD, 8'hFB).
  - Then press `button[1]` → next steps 8'h02, 8'h01, 8'h80.
- Priority and clear: in RUN, press `button[0]` and `button[3]` on the same cycle → PAUSE with `value` held, `run`=0. Release, then press `button[3]` → `led`=8'hFF, and `dir_down`/`shift_mode` are unchanged.
- Down wrap: press `button[1]` in IDLE, then start → first step `led`=8'h00 (`value` 8'hFF), then 8'h01 (`value` 8'hFE).
